// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: accepts a word on a valid/ready handshake and
// emits it one bit per clock, optionally followed by an even-parity bit.
module par2ser_tx #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              ser_o,
    output logic              ser_en_o,
    output logic              done_o,
    output logic              busy_o
);

    localparam int FRAME_LEN = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ser_q, ser_d;
    logic                   ser_en_q, ser_en_d;
    logic                   done_q, done_d;

    logic                   last_bit;
    logic                   accept;

    // The frame is held in send order so the outgoing bit is always the MSB.
    function automatic logic [FRAME_LEN-1:0] load_frame(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] ord;
        logic [DATA_W:0]   ext;
        for (int i = 0; i < DATA_W; i++) begin
            ord[i] = (MSB_FIRST != 0) ? w[i] : w[DATA_W-1-i];
        end
        ext = (PARITY_EN != 0) ? {ord, ^w} : {1'b0, ord};
        return FRAME_LEN'(ext);
    endfunction

    assign last_bit = (state_q == SHIFT) && (cnt_q == '0);
    assign ready_o  = (state_q == IDLE) || last_bit;
    assign accept   = valid_i && ready_o;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = load_frame(data_i);
            cnt_d   = CNT_LAST;
        end else if (last_bit) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - 1'b1;
        end

        // Outputs are registered from next-state values so they line up with the bit cycle.
        ser_en_d = (state_d == SHIFT);
        ser_d    = ser_en_d && shreg_d[FRAME_LEN-1];
        done_d   = ser_en_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            ser_q    <= 1'b0;
            ser_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            ser_q    <= ser_d;
            ser_en_q <= ser_en_d;
            done_q   <= done_d;
        end
    end

    assign ser_o    = ser_q;
    assign ser_en_o = ser_en_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q == SHIFT);

endmodule

// File: tb/tb_par2ser_tx.sv
// Directed bench for par2ser_tx: three instances cover MSB-first, LSB-first and
// parity-enabled framing; all stimulus driven and sampled on the falling edge.
module tb_par2ser_tx;

    logic       clk;
    logic       reset;
    logic [7:0] d [3];
    logic [2:0] v;
    logic [2:0] rdy, ser, sen, dn, bsy;

    int total;
    int bad;

    par2ser_tx #(.DATA_W(8), .MSB_FIRST(1), .PARITY_EN(0)) u_msb (
        .clk(clk), .reset(reset), .data_i(d[0]), .valid_i(v[0]), .ready_o(rdy[0]),
        .ser_o(ser[0]), .ser_en_o(sen[0]), .done_o(dn[0]), .busy_o(bsy[0]));

    par2ser_tx #(.DATA_W(8), .MSB_FIRST(0), .PARITY_EN(0)) u_lsb (
        .clk(clk), .reset(reset), .data_i(d[1]), .valid_i(v[1]), .ready_o(rdy[1]),
        .ser_o(ser[1]), .ser_en_o(sen[1]), .done_o(dn[1]), .busy_o(bsy[1]));

    par2ser_tx #(.DATA_W(8), .MSB_FIRST(1), .PARITY_EN(1)) u_par (
        .clk(clk), .reset(reset), .data_i(d[2]), .valid_i(v[2]), .ready_o(rdy[2]),
        .ser_o(ser[2]), .ser_en_o(sen[2]), .done_o(dn[2]), .busy_o(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int u, input string tag);
        chk($sformatf("%s.ser_en", tag), 32'(sen[u]), 32'd0);
        chk($sformatf("%s.ser", tag),    32'(ser[u]), 32'd0);
        chk($sformatf("%s.busy", tag),   32'(bsy[u]), 32'd0);
        chk($sformatf("%s.done", tag),   32'(dn[u]),  32'd0);
        chk($sformatf("%s.ready", tag),  32'(rdy[u]), 32'd1);
    endtask

    // Called at a falling edge with the unit idle. exp holds the send-order bits,
    // cycle k expects exp[len-k]. data_i is scrambled mid-frame; valid_i may be
    // pulsed at cycle pulse_k while the frame is still in flight.
    task automatic frame(input int u, input string tag, input logic [7:0] word,
                         input logic [8:0] exp, input int len, input int pulse_k);
        int ndone;
        ndone = 0;
        d[u] = word;
        v[u] = 1'b1;
        chk($sformatf("%s.ready0", tag), 32'(rdy[u]), 32'd1);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) v[u] = 1'b0;
            if (k == 2) d[u] = 8'hFF;
            chk($sformatf("%s.ser[%0d]", tag, k),    32'(ser[u]), 32'(exp[len-k]));
            chk($sformatf("%s.ser_en[%0d]", tag, k), 32'(sen[u]), 32'd1);
            chk($sformatf("%s.done[%0d]", tag, k),   32'(dn[u]),  32'(k == len));
            chk($sformatf("%s.ready[%0d]", tag, k),  32'(rdy[u]), 32'(k == len));
            chk($sformatf("%s.busy[%0d]", tag, k),   32'(bsy[u]), 32'd1);
            ndone += int'(dn[u]);
            if (k == pulse_k)     v[u] = 1'b1;
            if (k == pulse_k + 1) v[u] = 1'b0;
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk_idle(u, $sformatf("%s.after[%0d]", tag, k));
            ndone += int'(dn[u]);
        end
        chk($sformatf("%s.done_count", tag), 32'(ndone), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        v     = '0;
        for (int i = 0; i < 3; i++) d[i] = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) chk_idle(u, $sformatf("rst%0d", u));
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) chk_idle(u, $sformatf("postrst%0d", u));

        // MSB-first 0xA5 -> 1,0,1,0,0,1,0,1
        frame(0, "msb_a5", 8'hA5, 9'b0_1010_0101, 8, 0);
        // LSB-first 0x0D -> 1,0,1,1,0,0,0,0 with data_i changed mid-frame
        frame(1, "lsb_0d", 8'h0D, 9'b0_1011_0000, 8, 0);
        // Parity: 0xA5 has four ones -> parity 0; 0x07 has three -> parity 1
        frame(2, "par_a5", 8'hA5, 9'b1010_0101_0, 9, 0);
        frame(2, "par_07", 8'h07, 9'b0000_0111_1, 9, 0);

        // Back-to-back 0xFF then 0x00 with valid_i held high
        d[0] = 8'hFF;
        v[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) d[0] = 8'h00;
            if (k == 9) v[0] = 1'b0;
            chk($sformatf("b2b.ser[%0d]", k),    32'(ser[0]), 32'(k <= 8));
            chk($sformatf("b2b.ser_en[%0d]", k), 32'(sen[0]), 32'd1);
            chk($sformatf("b2b.done[%0d]", k),   32'(dn[0]),  32'((k == 8) || (k == 16)));
        end
        @(negedge clk);
        chk_idle(0, "b2b.end");

        // Asynchronous reset during bit 4 of 0xF0
        d[0] = 8'hF0;
        v[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) v[0] = 1'b0;
            chk($sformatf("rstmid.ser[%0d]", k), 32'(ser[0]), 32'd1);
        end
        chk("rstmid.busy_before", 32'(bsy[0]), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_idle(0, "rstmid.async");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk_idle(0, $sformatf("rstmid.release[%0d]", k));
        end
        frame(0, "rstmid_81", 8'h81, 9'b0_1000_0001, 8, 0);

        // valid_i pulse mid-frame is ignored: still exactly one frame
        frame(1, "pulse_3c", 8'h3C, 9'b0_0011_1100, 8, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/par2ser_tx.md
Name: par2ser_tx

Overview:
- Parallel-to-serial transmitter. It accepts one DATA_W-bit word through a valid/ready handshake and shifts it out one bit per clock on ser_o, with a bit-valid qualifier.
- It is the driving end of the single-bit serial link. A chain of simple DFF capture stages (a serial-to-parallel receiver) sits on the other end.
- It can optionally append an even-parity bit to each frame.

Parameters:
- DATA_W, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- PARITY_EN, 0, 1 = append one even-parity bit after the data bits (the XOR of all data bits).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset. Assertion clears all state immediately. Deassertion takes effect at the next posedge.
- data_i  input  DATA_W  word to transmit; sampled only on an accept edge.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a word this cycle.
- ser_o  output  1  serial data bit (registered).
- ser_en_o  output  1  ser_o carries a valid bit this cycle (registered).
- done_o  output  1  one-cycle pulse coincident with the final bit of a frame (registered).
- busy_o  output  1  a frame is in progress (state == SHIFT).

Behaviour:
- Frame length: FRAME_LEN = DATA_W + PARITY_EN bit cycles.
- FSM states:
  - IDLE: ser_en_o = 0, ser_o = 0, ready_o = 1.
  - SHIFT: a frame is being sent.
- Accept: valid_i && ready_o at a posedge.
  - data_i (plus the parity bit, if enabled) is loaded into the shift register and the bit counter is set to FRAME_LEN-1.
  - State goes to SHIFT.
- Latency: the first bit appears on ser_o with ser_en_o = 1 in the cycle immediately after the accept edge.
- Bit order:
  - Subsequent bits follow on consecutive cycles with no gaps.
  - Data bits go in MSB_FIRST order; the parity bit is always last.
- Counter: decrements once per bit cycle. The cycle in which the counter reads 0 is the last bit cycle.
  - done_o = 1 in that cycle only.
- ready_o (combinational from state and counter): 1 in IDLE, or in SHIFT during the last bit cycle; 0 otherwise.
- Last-bit-cycle transition:
  - If an accept occurs, the next frame's first bit appears in the following cycle. Back-to-back frames therefore have zero idle cycles between them.
  - Otherwise the state returns to IDLE, and ser_en_o and ser_o drop to 0 on the next cycle.
- While SHIFT and not in the last bit cycle: valid_i and data_i are ignored. The frame in flight is unaffected by changes on data_i.
- valid_i low while ready_o is high: no action; the state remains as is.
- Parity: computed from data_i at accept time (even parity, so the total count of ones including the parity bit is even).
- Reset (asserted at any time, including mid-frame):
  - State goes to IDLE; ser_o = 0, ser_en_o = 0, done_o = 0, busy_o = 0.
  - Shift register and counter are cleared.
  - ready_o = 1 while in IDLE.
  - The partial frame is discarded and is not resumed after reset release.
- No wrap or overflow condition: the counter width is $clog2(FRAME_LEN) and it never decrements below 0.

Test Plan:
1. DATA_W=8, MSB_FIRST=1, PARITY_EN=0: one accept of 0xA5.
   - Cycles 1..8 after accept: ser_o = 1,0,1,0,0,1,0,1 with ser_en_o = 1.
   - done_o high in cycle 8 only; ready_o = 0 in cycles 1..7.
   - Cycle 9: ser_en_o = 0.
2. MSB_FIRST=0: accept 0x0D.
   - ser_o = 1,0,1,1,0,0,0,0.
   - data_i changed to 0xFF in cycle 2 has no effect on the frame.
3. PARITY_EN=1: accept 0xA5 and then 0x07.
   - 0xA5: 9 bit cycles, the 9th bit = 0.
   - 0x07: the 9th bit = 1.
   - done_o lands on the 9th cycle in each frame.
4. Back-to-back: hold valid_i = 1, present 0xFF and then 0x00 on successive accepts.
   - ser_en_o high for 16 contiguous cycles: ser_o = eight 1s followed by eight 0s.
   - done_o pulses in cycles 8 and 16.
5. Reset mid-frame: accept 0xF0, then assert reset (drive it low) asynchronously between edges during bit 4.
   - ser_o, ser_en_o, and busy_o go to 0 immediately, without waiting for a clock edge.
   - After release, ready_o = 1 and no remaining bits are emitted.
   - A new accept of 0x81 transmits cleanly.
6. valid_i pulsed during SHIFT (not the last bit): the pulse is ignored. No extra frame is sent, and the word count stays at 1.
